// File: rtl/mac_pe.sv
// Fixed-point multiply-accumulate PE: 4-stage pipeline (input regs, product,
// saturating accumulate, round/saturate output) with a registered vector forward.
module mac_pe #(
    parameter int A_W   = 25,
    parameter int B_W   = 18,
    parameter int ACC_W = 48,
    parameter int FRAC  = 17,
    parameter int OUT_W = 25
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ce,
    input  logic                    sclr,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    subtract,
    input  logic signed [A_W-1:0]   ain,
    input  logic signed [B_W-1:0]   bin,
    output logic signed [A_W-1:0]   aout,
    output logic                    aout_valid,
    output logic signed [OUT_W-1:0] res,
    output logic                    res_valid,
    output logic                    res_ovf
);
    localparam int P_W = A_W + B_W;
    localparam int S_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [S_W-1:0]   RND     = S_W'(1) << (FRAC - 1);

    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             v1_q, v1_d, last1_q, last1_d, sub1_q, sub1_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             v2_q, v2_d, last2_q, last2_d, sub2_q, sub2_d;
    logic [ACC_W-1:0] acc_q, acc_d, fin_q, fin_d;
    logic             first_q, first_d, ovf_acc_q, ovf_acc_d;
    logic             fin_ovf_q, fin_ovf_d, v3_q, v3_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;

    logic signed [P_W-1:0] a_x, b_x;
    logic signed [S_W-1:0] base_x, p_x, sum_x, rnd_x, shr_x;
    logic [ACC_W-1:0]      acc_sat;
    logic                  acc_ovf;
    logic [S_W-OUT_W:0]    out_hi;
    logic [OUT_W-1:0]      out_sat;
    logic                  out_ovf;

    // Datapath: one guard bit above the accumulator makes overflow a sign-bit compare.
    always_comb begin
        a_x     = {{(P_W-A_W){a_q[A_W-1]}}, a_q};
        b_x     = {{(P_W-B_W){b_q[B_W-1]}}, b_q};
        base_x  = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
        p_x     = {{(S_W-P_W){p_q[P_W-1]}}, p_q};
        sum_x   = sub2_q ? (base_x - p_x) : (base_x + p_x);
        acc_ovf = sum_x[S_W-1] ^ sum_x[S_W-2];
        acc_sat = acc_ovf ? (sum_x[S_W-1] ? ACC_MIN : ACC_MAX) : sum_x[ACC_W-1:0];
        rnd_x   = {fin_q[ACC_W-1], fin_q} + RND;
        shr_x   = rnd_x >>> FRAC;
        out_hi  = shr_x[S_W-1:OUT_W-1];
        out_ovf = !((&out_hi) || !(|out_hi));
        out_sat = out_ovf ? (shr_x[S_W-1] ? OUT_MIN : OUT_MAX) : shr_x[OUT_W-1:0];
    end

    always_comb begin
        a_d = a_q;   b_d = b_q;   v1_d = v1_q;   last1_d = last1_q;   sub1_d = sub1_q;
        p_d = p_q;   v2_d = v2_q; last2_d = last2_q; sub2_d = sub2_q;
        acc_d = acc_q;   first_d = first_q;   ovf_acc_d = ovf_acc_q;
        fin_d = fin_q;   fin_ovf_d = fin_ovf_q;   v3_d = v3_q;
        res_d = res_q;   res_valid_d = res_valid_q;   res_ovf_d = res_ovf_q;
        if (sclr) begin
            v1_d = 1'b0;  v2_d = 1'b0;  v3_d = 1'b0;  res_valid_d = 1'b0;
            acc_d = '0;   first_d = 1'b1;  ovf_acc_d = 1'b0;
        end else if (ce) begin
            a_d = ain;  b_d = bin;  v1_d = in_valid;  last1_d = in_last;  sub1_d = subtract;
            p_d = a_x * b_x;
            v2_d = v1_q;  last2_d = last1_q;  sub2_d = sub1_q;
            v3_d = v2_q & last2_q;
            if (v2_q) begin
                if (last2_q) begin
                    fin_d     = acc_sat;
                    fin_ovf_d = ovf_acc_q | acc_ovf;
                    acc_d     = '0;
                    first_d   = 1'b1;
                    ovf_acc_d = 1'b0;
                end else begin
                    acc_d     = acc_sat;
                    first_d   = 1'b0;
                    ovf_acc_d = ovf_acc_q | acc_ovf;
                end
            end
            res_valid_d = v3_q;
            if (v3_q) begin
                res_d     = out_sat;
                res_ovf_d = fin_ovf_q | out_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;  b_q <= '0;  v1_q <= 1'b0;  last1_q <= 1'b0;  sub1_q <= 1'b0;
            p_q <= '0;  v2_q <= 1'b0;  last2_q <= 1'b0;  sub2_q <= 1'b0;
            acc_q <= '0;  first_q <= 1'b1;  ovf_acc_q <= 1'b0;
            fin_q <= '0;  fin_ovf_q <= 1'b0;  v3_q <= 1'b0;
            res_q <= '0;  res_valid_q <= 1'b0;  res_ovf_q <= 1'b0;
        end else begin
            a_q <= a_d;  b_q <= b_d;  v1_q <= v1_d;  last1_q <= last1_d;  sub1_q <= sub1_d;
            p_q <= p_d;  v2_q <= v2_d;  last2_q <= last2_d;  sub2_q <= sub2_d;
            acc_q <= acc_d;  first_q <= first_d;  ovf_acc_q <= ovf_acc_d;
            fin_q <= fin_d;  fin_ovf_q <= fin_ovf_d;  v3_q <= v3_d;
            res_q <= res_d;  res_valid_q <= res_valid_d;  res_ovf_q <= res_ovf_d;
        end
    end

    assign aout       = a_q;
    assign aout_valid = v1_q;
    assign res        = res_q;
    assign res_valid  = res_valid_q;
    assign res_ovf    = res_ovf_q;
endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: directed rows plus random rows, scored against a
// saturating integer dot-product model with an expected-result queue.
module tb_mac_pe;
    localparam int A_W = 25, B_W = 18, ACC_W = 48, FRAC = 17, OUT_W = 25;
    localparam int ONE = 131072;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));
    localparam longint OUT_MAX = (64'sd1 <<< (OUT_W-1)) - 1;
    localparam longint OUT_MIN = -(64'sd1 <<< (OUT_W-1));

    logic clk = 1'b0, rstn = 1'b0, ce = 1'b1, sclr = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, subtract = 1'b0;
    logic signed [A_W-1:0]   ain = '0;
    logic signed [B_W-1:0]   bin = '0;
    logic signed [A_W-1:0]   aout;
    logic                    aout_valid, res_valid, res_ovf;
    logic signed [OUT_W-1:0] res;

    int checks = 0, errors = 0, en_cnt = 0;
    logic [OUT_W:0] exp_q[$];
    int             exp_t_q[$];
    longint         row_acc = 0;
    bit             row_ovf = 1'b0;

    mac_pe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rstn(rstn), .ce(ce), .sclr(sclr), .in_valid(in_valid),
        .in_last(in_last), .subtract(subtract), .ain(ain), .bin(bin),
        .aout(aout), .aout_valid(aout_valid), .res(res), .res_valid(res_valid),
        .res_ovf(res_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) if (ce) en_cnt++;
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // reference model: exact dot product with saturation at accumulator bounds
    function automatic void model_elem(input logic last, input logic sub,
                                       input logic signed [A_W-1:0] a,
                                       input logic signed [B_W-1:0] b);
        longint p, r, q;
        p = longint'(a) * longint'(b);
        row_acc = sub ? row_acc - p : row_acc + p;
        if (row_acc > ACC_MAX) begin row_acc = ACC_MAX; row_ovf = 1'b1; end
        if (row_acc < ACC_MIN) begin row_acc = ACC_MIN; row_ovf = 1'b1; end
        if (last) begin
            r = row_acc + (64'sd1 <<< (FRAC-1));
            q = r >>> FRAC;
            if (q > OUT_MAX) begin q = OUT_MAX; row_ovf = 1'b1; end
            if (q < OUT_MIN) begin q = OUT_MIN; row_ovf = 1'b1; end
            exp_q.push_back({row_ovf, q[OUT_W-1:0]});
            exp_t_q.push_back(en_cnt + 3);
            row_acc = 0;
            row_ovf = 1'b0;
        end
    endfunction

    // driver: one clock of stimulus, then aout forwarding check
    task automatic step(input logic v, input logic l, input logic s,
                        input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b);
        in_valid = v; in_last = l; subtract = s; ain = a; bin = b;
        @(posedge clk); #1;
        if (sclr) begin
            row_acc = 0;
            row_ovf = 1'b0;
        end else if (ce && rstn) begin
            checks++;
            if (aout !== a || aout_valid !== v) begin
                errors++;
                $display("FAIL aout_fwd got a=%0d v=%0b want a=%0d v=%0b", aout, aout_valid, a, v);
            end
            if (v) model_elem(l, s, a, b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, A_W'($urandom), B_W'($urandom));
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (aout !== '0 || aout_valid !== 1'b0 || res !== '0 || res_valid !== 1'b0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s got aout=%0d av=%0b res=%0d rv=%0b ro=%0b want all 0",
                     name, aout, aout_valid, res, res_valid, res_ovf);
        end
    endtask

    // scoreboard monitor: a result counts once, on a cycle where ce is high
    always @(negedge clk) begin
        if (rstn && ce && res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got res=%0d ovf=%0b want none", res, res_ovf);
            end else begin
                logic [OUT_W:0] e;
                int t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                if ({res_ovf, res} !== e || en_cnt != t) begin
                    errors++;
                    $display("FAIL result got res=%0d ovf=%0b at %0d want res=%0d ovf=%0b at %0d",
                             res, res_ovf, en_cnt, $signed(e[OUT_W-1:0]), e[OUT_W], t);
                end
            end
        end
    end

    initial begin
        int len;
        bit big;
        logic signed [A_W-1:0] ra;
        logic signed [B_W-1:0] rb;
        #3;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle(2);

        // dot product: 4 x (1.0 * 3) -> 12
        for (int i = 0; i < 4; i++) step(1'b1, i == 3, 1'b0, ONE, 3);
        idle(2);
        // rounding
        step(1'b1, 1'b1, 1'b0, 65536, 1);
        step(1'b1, 1'b1, 1'b0, 65535, 1);
        step(1'b1, 1'b1, 1'b0, -65536, 1);
        step(1'b1, 1'b1, 1'b0, -196608, 1);
        idle(2);
        // output saturation, then a clean row
        step(1'b1, 1'b0, 1'b0, (1 << 24) - 1, (1 << 17) - 1);
        step(1'b1, 1'b1, 1'b0, (1 << 24) - 1, (1 << 17) - 1);
        step(1'b1, 1'b1, 1'b0, ONE, 5);
        idle(2);
        // bubble and subtract inside a row, second row back to back
        step(1'b1, 1'b0, 1'b0, ONE, 2);
        step(1'b0, 1'b0, 1'b0, 77, 9);
        step(1'b1, 1'b1, 1'b1, ONE, 1);
        step(1'b1, 1'b1, 1'b0, ONE, 7);
        idle(5);
        // ce low mid-row and while a result is in flight
        step(1'b1, 1'b0, 1'b0, ONE, 4);
        ce = 1'b0; for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, ONE, 100); ce = 1'b1;
        step(1'b1, 1'b1, 1'b0, ONE, 5);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        ce = 1'b0; for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0); ce = 1'b1;
        idle(5);
        // sclr discards a partial row
        step(1'b1, 1'b0, 1'b0, ONE, 9);
        step(1'b1, 1'b0, 1'b0, ONE, 9);
        sclr = 1'b1; step(1'b0, 1'b0, 1'b0, 0, 0); sclr = 1'b0;
        step(1'b1, 1'b1, 1'b0, ONE, 2);
        idle(5);
        // asynchronous reset mid-row
        step(1'b1, 1'b0, 1'b0, ONE, 5);
        step(1'b1, 1'b0, 1'b0, ONE, 5);
        #2 rstn = 1'b0;
        #1 check_zero("async_reset");
        row_acc = 0; row_ovf = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rstn = 1'b1;
        idle(2);
        step(1'b1, 1'b1, 1'b0, ONE, 6);
        idle(5);
        // accumulator saturation is sticky even when the row comes back in range
        for (int i = 0; i < 66; i++) step(1'b1, 1'b0, 1'b0, -(1 << 24), -(1 << 17));
        for (int i = 0; i < 64; i++) step(1'b1, i == 63, 1'b1, -(1 << 24), -(1 << 17));
        idle(5);
        // random rows with bubbles, subtract and stalls
        for (int r = 0; r < 150; r++) begin
            len = $urandom_range(1, 6);
            big = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, A_W'($urandom), B_W'($urandom));
                if ($urandom_range(0, 7) == 0) begin
                    ce = 1'b0;
                    step(1'b1, 1'b1, 1'b0, A_W'($urandom), B_W'($urandom));
                    ce = 1'b1;
                end
                ra = big ? A_W'($urandom) : A_W'($signed($urandom_range(0, 1 << 19)) - (1 << 18));
                rb = big ? B_W'($urandom) : B_W'($signed($urandom_range(0, 1 << 12)) - (1 << 11));
                step(1'b1, k == len - 1, 1'($urandom_range(0, 1)), ra, rb);
            end
        end
        // drain with a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
